// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use detection; ID fields appear on ID_EX_* one cycle after sampling.
// A load-use hazard holds PC and IF/ID (stall) for STALL_CYCLES cycles while bubbles enter EX; flush overrides.
module id_ex_hazard_stage #(
    parameter int N            = 32,
    parameter int STALL_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         id_valid,
    input  logic [4:0]   IF_ID_Register_Rs1,
    input  logic [4:0]   IF_ID_Register_Rs2,
    input  logic [4:0]   IF_ID_Register_Rd,
    input  logic [N-1:0] id_read_data1,
    input  logic [N-1:0] id_read_data2,
    input  logic [N-1:0] id_imm,
    input  logic [N-1:0] id_pc,
    input  logic [2:0]   id_alu_op,
    input  logic         id_RegWrite,
    input  logic         id_MemRead,
    input  logic         id_MemWrite,
    input  logic         id_MemtoReg,
    input  logic         id_ALUSrc,
    output logic [4:0]   ID_EX_Register_Rs1,
    output logic [4:0]   ID_EX_Register_Rs2,
    output logic [4:0]   ID_EX_Register_Rd,
    output logic [N-1:0] ID_EX_read_data1,
    output logic [N-1:0] ID_EX_read_data2,
    output logic [N-1:0] ID_EX_imm,
    output logic [N-1:0] ID_EX_pc,
    output logic [2:0]   ID_EX_alu_op,
    output logic         ID_EX_RegWrite,
    output logic         ID_EX_MemRead,
    output logic         ID_EX_MemWrite,
    output logic         ID_EX_MemtoReg,
    output logic         ID_EX_ALUSrc,
    output logic         ID_EX_valid,
    output logic         hazard_selector,
    output logic         stall
);

    typedef enum logic {S_RUN, S_STALL} state_t;

    localparam logic [1:0] CNT_INIT = 2'(STALL_CYCLES - 1);

    state_t       r_state, w_state_nxt;
    logic [1:0]   r_cnt, w_cnt_nxt;
    logic         w_lu_hit, w_bubble;

    logic [4:0]   r_rs1, r_rs2, r_rd;
    logic [N-1:0] r_rd1, r_rd2, r_imm, r_pc;
    logic [2:0]   r_alu_op;
    logic         r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
    logic         r_valid, r_hazard_sel;

    assign w_lu_hit = r_valid & r_mem_read & (r_rd != 5'd0) & id_valid &
                      ((r_rd == IF_ID_Register_Rs1) | (r_rd == IF_ID_Register_Rs2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Reset outranks everything, so stall is forced low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bubble    = 1'b0;
        stall       = 1'b0;
        if (reset) begin
            case (r_state)
                S_RUN: begin
                    if (flush) begin
                        w_bubble = 1'b1;
                    end else if (w_lu_hit) begin
                        stall       = 1'b1;
                        w_bubble    = 1'b1;
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = (CNT_INIT != 2'd0) ? S_STALL : S_RUN;
                    end
                end
                S_STALL: begin
                    w_bubble = 1'b1;
                    if (flush) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = 2'd0;
                    end else begin
                        stall = 1'b1;
                        if (r_cnt <= 2'd1) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = 2'd0;
                        end else begin
                            w_cnt_nxt = r_cnt - 2'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Bubbles clear control and register ids; data and pc keep their stale values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_alu_op     <= 3'd0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_valid      <= 1'b0;
            r_hazard_sel <= 1'b1;
        end else if (w_bubble) begin
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
            r_alu_op     <= 3'd0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_valid      <= 1'b0;
            r_hazard_sel <= 1'b1;
        end else begin
            r_rs1        <= IF_ID_Register_Rs1;
            r_rs2        <= IF_ID_Register_Rs2;
            r_rd         <= IF_ID_Register_Rd;
            r_rd1        <= id_read_data1;
            r_rd2        <= id_read_data2;
            r_imm        <= id_imm;
            r_pc         <= id_pc;
            r_alu_op     <= id_alu_op;
            r_reg_write  <= id_RegWrite;
            r_mem_read   <= id_MemRead;
            r_mem_write  <= id_MemWrite;
            r_mem_to_reg <= id_MemtoReg;
            r_alu_src    <= id_ALUSrc;
            r_valid      <= id_valid;
            r_hazard_sel <= ~id_valid;
        end
    end

    assign ID_EX_Register_Rs1 = r_rs1;
    assign ID_EX_Register_Rs2 = r_rs2;
    assign ID_EX_Register_Rd  = r_rd;
    assign ID_EX_read_data1   = r_rd1;
    assign ID_EX_read_data2   = r_rd2;
    assign ID_EX_imm          = r_imm;
    assign ID_EX_pc           = r_pc;
    assign ID_EX_alu_op       = r_alu_op;
    assign ID_EX_RegWrite     = r_reg_write;
    assign ID_EX_MemRead      = r_mem_read;
    assign ID_EX_MemWrite     = r_mem_write;
    assign ID_EX_MemtoReg     = r_mem_to_reg;
    assign ID_EX_ALUSrc       = r_alu_src;
    assign ID_EX_valid        = r_valid;
    assign hazard_selector    = r_hazard_sel;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: two instances (1 and 3 stall cycles) each fed from its own view of a shared
// instruction stream, compared every cycle against a per-instance reference model plus directed checks.
module tb_id_ex_hazard_stage;

    localparam int N = 32;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic [2:0]  alu;
        logic        rw, mrd, mwr, m2r, asrc;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic [2:0]  alu;
        logic        rw, mrd, mwr, m2r, asrc, valid, hs;
    } stage_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    instr_t cur [2];

    logic [4:0]   o_rs1 [2], o_rs2 [2], o_rd [2];
    logic [N-1:0] o_d1 [2], o_d2 [2], o_imm [2], o_pc [2];
    logic [2:0]   o_alu [2];
    logic         o_rw [2], o_mrd [2], o_mwr [2], o_m2r [2], o_asrc [2];
    logic         o_valid [2], o_hs [2], o_stall [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_ex_hazard_stage #(.N(N), .STALL_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .reset(rst), .flush(flush), .id_valid(cur[g].v),
            .IF_ID_Register_Rs1(cur[g].rs1), .IF_ID_Register_Rs2(cur[g].rs2), .IF_ID_Register_Rd(cur[g].rd),
            .id_read_data1(cur[g].d1), .id_read_data2(cur[g].d2), .id_imm(cur[g].imm), .id_pc(cur[g].pc),
            .id_alu_op(cur[g].alu), .id_RegWrite(cur[g].rw), .id_MemRead(cur[g].mrd),
            .id_MemWrite(cur[g].mwr), .id_MemtoReg(cur[g].m2r), .id_ALUSrc(cur[g].asrc),
            .ID_EX_Register_Rs1(o_rs1[g]), .ID_EX_Register_Rs2(o_rs2[g]), .ID_EX_Register_Rd(o_rd[g]),
            .ID_EX_read_data1(o_d1[g]), .ID_EX_read_data2(o_d2[g]), .ID_EX_imm(o_imm[g]), .ID_EX_pc(o_pc[g]),
            .ID_EX_alu_op(o_alu[g]), .ID_EX_RegWrite(o_rw[g]), .ID_EX_MemRead(o_mrd[g]),
            .ID_EX_MemWrite(o_mwr[g]), .ID_EX_MemtoReg(o_m2r[g]), .ID_EX_ALUSrc(o_asrc[g]),
            .ID_EX_valid(o_valid[g]), .hazard_selector(o_hs[g]), .stall(o_stall[g])
        );
    end

    int n_checks = 0;
    int n_err = 0;
    int stall_len [2] = '{0, 0};
    int sc [2] = '{1, 3};
    instr_t prog [$];
    int idx [2] = '{0, 0};
    stage_t m_reg [2];
    int m_rem [2] = '{0, 0};
    bit known [2] = '{0, 0};

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic stage_t get_obs(input int k);
        stage_t s;
        s = '{rs1: o_rs1[k], rs2: o_rs2[k], rd: o_rd[k], d1: o_d1[k], d2: o_d2[k], imm: o_imm[k],
              pc: o_pc[k], alu: o_alu[k], rw: o_rw[k], mrd: o_mrd[k], mwr: o_mwr[k], m2r: o_m2r[k],
              asrc: o_asrc[k], valid: o_valid[k], hs: o_hs[k]};
        return s;
    endfunction

    function automatic instr_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                  input logic mrd, input logic rw);
        instr_t i;
        i = '{v: v, rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'(rd), d1: $urandom, d2: $urandom, imm: $urandom,
              pc: $urandom, alu: 3'($urandom_range(0, 7)), rw: rw, mrd: mrd,
              mwr: 1'($urandom_range(0, 1)), m2r: mrd, asrc: 1'($urandom_range(0, 1))};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        return mk($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    // One cycle: drive each instance's IF/ID view, compare against the model, then advance the model.
    task automatic tick();
        for (int k = 0; k < 2; k++) cur[k] = (idx[k] < prog.size()) ? prog[idx[k]] : '0;
        #2;
        for (int k = 0; k < 2; k++) begin
            logic hit, es;
            stage_t nx;
            hit = m_reg[k].valid && m_reg[k].mrd && (m_reg[k].rd != 0) && cur[k].v &&
                  (m_reg[k].rd == cur[k].rs1 || m_reg[k].rd == cur[k].rs2);
            es = rst && !flush && (m_rem[k] > 0 || hit);
            if (known[k]) begin
                check($sformatf("regs%0d", k), get_obs(k), m_reg[k]);
                check($sformatf("stall%0d", k), o_stall[k], es);
            end
            stall_len[k] += int'(o_stall[k]);
            nx = m_reg[k];
            nx.rs1 = 0; nx.rs2 = 0; nx.rd = 0; nx.alu = 0;
            nx.rw = 0; nx.mrd = 0; nx.mwr = 0; nx.m2r = 0; nx.asrc = 0; nx.valid = 0; nx.hs = 1;
            if (!rst) begin
                nx = '0; nx.hs = 1; m_rem[k] = 0; known[k] = 1;
            end else if (flush) begin
                m_rem[k] = 0;
            end else if (m_rem[k] > 0) begin
                m_rem[k]--;
            end else if (hit) begin
                m_rem[k] = sc[k] - 1;
            end else begin
                nx = '{rs1: cur[k].rs1, rs2: cur[k].rs2, rd: cur[k].rd, d1: cur[k].d1, d2: cur[k].d2,
                       imm: cur[k].imm, pc: cur[k].pc, alu: cur[k].alu, rw: cur[k].rw, mrd: cur[k].mrd,
                       mwr: cur[k].mwr, m2r: cur[k].m2r, asrc: cur[k].asrc, valid: cur[k].v, hs: !cur[k].v};
            end
            m_reg[k] = nx;
            if (!es && idx[k] < prog.size()) idx[k]++;
        end
        @(posedge clk);
        #1;
    endtask

    // Runs queued instructions to completion with flush on the ticks set in fpat, then one idle tick.
    task automatic run_seg(input int budget, input logic [31:0] fpat);
        int t = 0;
        stall_len = '{0, 0};
        while ((idx[0] < prog.size() || idx[1] < prog.size()) && t < budget) begin
            flush = (t < 32) ? fpat[t] : 1'b0;
            tick();
            t++;
        end
        flush = 1'b0;
        if (t >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required under %0d", t, budget);
        end
        tick();
    endtask

    initial begin
        stage_t zr;
        zr = '0;
        zr.hs = 1'b1;
        cur[0] = '0;
        cur[1] = '0;
        @(posedge clk);
        #1;

        // Reset with random inputs for two cycles
        for (int i = 0; i < 3; i++) prog.push_back(rand_instr());
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_regs%0d", k), get_obs(k), zr);
            check($sformatf("rst_stall%0d", k), o_stall[k], 1'b0);
        end
        run_seg(20, 32'h0);

        // Passthrough
        begin
            instr_t p;
            p = mk(1'b1, 5, 6, 7, 1'b0, 1'b1);
            p.d1 = 32'h1234;
            prog.push_back(p);
            tick();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("pass_d1_%0d", k), o_d1[k], 32'h1234);
                check($sformatf("pass_ids_%0d", k), {o_rs1[k], o_rs2[k], o_rd[k]}, {5'd5, 5'd6, 5'd7});
                check($sformatf("pass_ctl_%0d", k), {o_rw[k], o_valid[k], o_hs[k], o_stall[k]}, 4'b1100);
            end
            run_seg(20, 32'h0);
        end

        // Load-use: lw x3 then add x4,x3,x1
        prog.push_back(mk(1'b1, 1, 2, 3, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 3, 1, 4, 1'b0, 1'b1));
        run_seg(20, 32'h0);
        check("lu_len_1", stall_len[0], 1);
        check("lu_len_3", stall_len[1], 3);

        // lw x0 then x0 use; lw x3 then use of x5 only
        prog.push_back(mk(1'b1, 1, 2, 0, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 0, 0, 4, 1'b0, 1'b1));
        prog.push_back(mk(1'b1, 1, 2, 3, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 5, 5, 6, 1'b0, 1'b1));
        run_seg(20, 32'h0);
        check("nohit_len_1", stall_len[0], 0);
        check("nohit_len_3", stall_len[1], 0);

        // Flush coincident with the hazard
        prog.push_back(mk(1'b1, 1, 2, 3, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 3, 1, 4, 1'b0, 1'b1));
        run_seg(20, 32'h2);
        check("fl_hit_len_1", stall_len[0], 0);
        check("fl_hit_len_3", stall_len[1], 0);

        // Flush in the second stall cycle
        prog.push_back(mk(1'b1, 1, 2, 3, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 1, 3, 4, 1'b0, 1'b1));
        run_seg(20, 32'h4);
        check("fl_mid_len_1", stall_len[0], 1);
        check("fl_mid_len_3", stall_len[1], 1);

        // Random stream with occasional flush and reset
        for (int i = 0; i < 400; i++) prog.push_back(rand_instr());
        begin
            int t = 0;
            while ((idx[0] < prog.size() || idx[1] < prog.size()) && t < 3000) begin
                flush = $urandom_range(0, 99) < 8;
                rst = $urandom_range(0, 199) != 0;
                tick();
                t++;
            end
            flush = 1'b0;
            rst = 1'b1;
            if (t >= 3000) begin
                n_checks++;
                n_err++;
                $display("FAIL rand_timeout: still busy after %0d cycles, required under 3000", t);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
